bit_debouncer: RTL
==================

Name: bit_debouncer

Overview:
- Input-conditioning stage directly upstream of the 1-bit load register (Bit).
- Takes a raw, asynchronous, bouncy pin (button/switch) and synchronises it into CLK.
- Filters glitches and drives the register's data and load inputs: OUT feeds IN, LOAD feeds LOAD.
- Also provides single-cycle RISE/FALL event pulses for the rest of the design.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on PIN; legal range 2..4.
- STABLE_CYCLES, 4, consecutive synchronised cycles at the new level before a change is accepted; legal ≥1.
- CNT_WIDTH, 8, width of the stability counter; must satisfy 2^CNT_WIDTH > STABLE_CYCLES.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- RESET_N  input  1  synchronous reset, active-low.
- PIN  input  1  raw asynchronous input.
- OUT  output  1  debounced level; connects to Bit.IN.
- LOAD  output  1  one-cycle pulse, high in the first cycle OUT holds a new value; connects to Bit.LOAD.
- RISE  output  1  one-cycle pulse on an accepted 0→1 change, coincident with LOAD.
- FALL  output  1  one-cycle pulse on an accepted 1→0 change, coincident with LOAD.
- TOGGLE  output  1  see Optional Feature.

Behaviour:
- Clock and reset:
  - One clock, CLK. RESET_N is synchronous and active-low.
  - RESET_N=0 at a posedge clears all synchroniser flops, the counter, OUT, LOAD, RISE, FALL and TOGGLE to 0, and sets the state to S_LO.
- Synchroniser: PIN passes through SYNC_STAGES flops; the last stage is SYNC. No other logic samples PIN.
- FSM, 2-bit state: S_LO, S_PEND_HI, S_HI, S_PEND_LO.
  - S_LO: if SYNC=1, go to S_PEND_HI and set cnt=1; else hold.
  - S_PEND_HI:
    - SYNC=0: return to S_LO, cnt=0 (bounce rejected, no output activity).
    - SYNC=1 and cnt==STABLE_CYCLES-1: go to S_HI, OUT<=1, LOAD<=1, RISE<=1, cnt=0.
    - Otherwise: cnt<=cnt+1.
  - S_HI and S_PEND_LO: mirror image of the above. Acceptance gives OUT<=0, LOAD<=1, FALL<=1.
  - STABLE_CYCLES=1: S_PEND_* is skipped; acceptance occurs directly from S_LO/S_HI on the first cycle SYNC differs from OUT.
- Pulses:
  - LOAD, RISE and FALL are registered. Each is high for exactly one cycle, the cycle after the acceptance edge.
  - All three are deasserted in every other cycle.
  - RISE and FALL are never high together.
- Latency: a clean step on PIN, first sampled at edge 0, changes OUT at edge SYNC_STAGES+STABLE_CYCLES-1. LOAD is high during the following cycle.
- Bit contract: Bit captures OUT on the edge where LOAD=1, so Bit.OUT equals debouncer OUT one edge after the pulse. Any Bit holding a value must not miss an accepted transition.
- Counter:
  - Saturating is not needed because acceptance always clears it.
  - cnt never exceeds STABLE_CYCLES-1.
  - cnt is unsigned, CNT_WIDTH bits.
- Boundary cases:
  - A bounce on the final pending cycle still rejects.
  - PIN toggling every cycle produces no LOAD.
  - Reset asserted mid-pend discards the pending change. If PIN=1 is held through reset, OUT rises SYNC_STAGES+STABLE_CYCLES-1 edges after RESET_N returns to 1.
  - Back-to-back accepted transitions are separated by at least STABLE_CYCLES cycles.

Optional Feature:
- Macro: BIT_DEBOUNCER_TOGGLE_EN.
- Defined:
  - TOGGLE is a registered level that inverts on every accepted rising edge, in the same cycle OUT rises. Falls do not affect it.
  - Reset value is 0.
  - Used as a push-on/push-off source for a Bit register.
- Undefined: TOGGLE is tied to constant 0 and no toggle flop is synthesised. The port list is unchanged.

Test Plan (SYNC_STAGES=2, STABLE_CYCLES=4 unless noted):
- Reset: hold RESET_N=0 for 3 cycles with PIN=1 → OUT, LOAD, RISE, FALL and TOGGLE all 0 throughout.
- Clean rise: PIN 0→1 sampled at edge 0, held → OUT=1 after edge 5; LOAD=RISE=1 for exactly one cycle after edge 5; FALL=0.
- Bounce rejection: PIN pattern 1,1,0,1,1,0 then 0 held → no LOAD/RISE, OUT stays 0.
- Clean fall: from OUT=1, PIN→0 held → OUT=0 after 5 edges, with one LOAD+FALL pulse; downstream Bit reads 0 one edge after the pulse.
- Reset mid-pend: PIN=1 for 3 cycles, then RESET_N=0 for 1 cycle, then PIN held 1 → OUT rises exactly 5 edges after reset release.
- STABLE_CYCLES=1 with BIT_DEBOUNCER_TOGGLE_EN defined: three clean presses → OUT rises after 2 edges each time; TOGGLE goes 1,0,1 on successive rises and is unaffected by falls.

Source files
------------

// File: rtl/bit_debouncer.sv
// Synchronises and debounces a raw pin into OUT with LOAD/RISE/FALL pulses.
// Define BIT_DEBOUNCER_TOGGLE_EN to enable the push-on/push-off TOGGLE output.
module bit_debouncer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_WIDTH     = 8
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic PIN,
    output logic OUT,
    output logic LOAD,
    output logic RISE,
    output logic FALL,
    output logic TOGGLE
);

    typedef enum logic [1:0] {
        S_LO      = 2'd0,
        S_PEND_HI = 2'd1,
        S_HI      = 2'd2,
        S_PEND_LO = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LP_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] LP_ONE  = CNT_WIDTH'(1);
    localparam bit                   LP_DIRECT = (STABLE_CYCLES == 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [CNT_WIDTH-1:0]   w_cnt_nxt;
    logic                   r_out;
    logic                   w_out_nxt;
    logic                   r_load;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_rise_nxt;
    logic                   w_fall_nxt;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], PIN};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state <= S_LO;
            r_cnt   <= '0;
            r_out   <= 1'b0;
            r_load  <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
            r_load  <= w_rise_nxt | w_fall_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    // Pending states count consecutive samples at the candidate level.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_out_nxt   = r_out;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        unique case (r_state)
            S_LO: begin
                if (w_sync) begin
                    if (LP_DIRECT) begin
                        w_state_nxt = S_HI;
                        w_cnt_nxt   = '0;
                        w_out_nxt   = 1'b1;
                        w_rise_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_PEND_HI;
                        w_cnt_nxt   = LP_ONE;
                    end
                end
            end
            S_PEND_HI: begin
                if (!w_sync) begin
                    w_state_nxt = S_LO;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LP_LAST) begin
                    w_state_nxt = S_HI;
                    w_cnt_nxt   = '0;
                    w_out_nxt   = 1'b1;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + LP_ONE;
                end
            end
            S_HI: begin
                if (!w_sync) begin
                    if (LP_DIRECT) begin
                        w_state_nxt = S_LO;
                        w_cnt_nxt   = '0;
                        w_out_nxt   = 1'b0;
                        w_fall_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_PEND_LO;
                        w_cnt_nxt   = LP_ONE;
                    end
                end
            end
            S_PEND_LO: begin
                if (w_sync) begin
                    w_state_nxt = S_HI;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LP_LAST) begin
                    w_state_nxt = S_LO;
                    w_cnt_nxt   = '0;
                    w_out_nxt   = 1'b0;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + LP_ONE;
                end
            end
            default: begin
                w_state_nxt = S_LO;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign OUT  = r_out;
    assign LOAD = r_load;
    assign RISE = r_rise;
    assign FALL = r_fall;

`ifdef BIT_DEBOUNCER_TOGGLE_EN
    logic r_toggle;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_toggle <= 1'b0;
        end else if (w_rise_nxt) begin
            r_toggle <= ~r_toggle;
        end
    end

    assign TOGGLE = r_toggle;
`else
    assign TOGGLE = 1'b0;
`endif

endmodule
